// File: rtl/config_flit_engine.sv
// Configuration flit front end: credit-managed input FIFO, command decode, config bus and read-back replies.
// Optional build macro CFG_PARITY_EN: flit bit FW-1 carries even parity over the used fields (adds err_parity).
module config_flit_engine #(
    parameter int             FW       = 59,
    parameter int             FTW      = 3,
    parameter logic [FTW-1:0] CFG_TYPE = 3'b100,
    parameter int             CAW      = 15,
    parameter int             CDW      = 21,
    parameter int             XW       = 4,
    parameter int             YW       = 4,
    parameter int             FDW      = 2,
    parameter int             BCW      = 8,
    parameter int             RD_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spk_in_config_we,
    input  logic [FW-1:0]        spk_in_config_wdata,
    output logic                 config_spk_in_credit,
    input  logic                 hold,
    output logic                 cfg_we,
    output logic [CAW-1:0]       cfg_waddr,
    output logic [CDW-1:0]       cfg_wdata,
    output logic                 cfg_re,
    output logic [CAW-1:0]       cfg_raddr,
    input  logic [CDW-1:0]       cfg_rdata,
    input  logic                 spk_out_config_full,
    output logic                 cfg_reply_we,
    output logic [XW+YW+CDW-1:0] cfg_reply_wdata,
    output logic                 busy,
    output logic                 err_overflow,
`ifdef CFG_PARITY_EN
    output logic                 err_parity,
`endif
    output logic                 err_proto
);

    localparam int UW    = FTW + 2 + CAW + CDW + XW + YW;
    localparam int X_LSB = YW;
    localparam int D_LSB = YW + XW;
    localparam int A_LSB = D_LSB + CDW;
    localparam int O_LSB = A_LSB + CAW;
    localparam int T_LSB = O_LSB + 2;
    localparam int DEPTH = 1 << FDW;

    localparam logic [FDW:0]   CNT_FULL = (FDW+1)'(DEPTH);
    localparam logic [FDW:0]   CNT_ONE  = (FDW+1)'(1);
    localparam logic [FDW-1:0] PTR_ONE  = FDW'(1);
    localparam logic [CAW-1:0] ADDR_ONE = CAW'(1);
    localparam logic [BCW-1:0] BCNT_ONE = BCW'(1);
    localparam logic [2:0]     LAT_END  = 3'(RD_LAT);

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_REPLY   = 3'd4;
    localparam logic [2:0] S_BURST   = 3'd5;

    function automatic logic f_parity_ok(input logic [FW-1:0] flit);
        return ~(^{flit[FW-1], flit[UW-1:0]});
    endfunction

    logic [FW-1:0]         r_mem [DEPTH];
    logic [FDW-1:0]        r_wptr;
    logic [FDW-1:0]        r_rptr;
    logic [FDW:0]          r_count;
    logic                  r_err_overflow;

    logic [2:0]            r_state;
    logic                  r_hold;
    logic                  r_we;
    logic [CAW-1:0]        r_waddr;
    logic [CDW-1:0]        r_wdata;
    logic                  r_re;
    logic [CAW-1:0]        r_raddr;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [2:0]            r_lat;
    logic [CDW-1:0]        r_rdata;
    logic                  r_reply_we;
    logic [XW+YW+CDW-1:0]  r_reply_wdata;
    logic [CAW-1:0]        r_base;
    logic [BCW-1:0]        r_rem;
    logic                  r_err_proto;
    logic                  r_err_parity;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [FW-1:0]         w_head;
    logic [FTW-1:0]        w_type;
    logic [1:0]            w_op;
    logic [CAW-1:0]        w_addr;
    logic [CDW-1:0]        w_data;
    logic [XW-1:0]         w_x;
    logic [YW-1:0]         w_y;
    logic                  w_is_cfg;
    logic                  w_par_ok;
    logic                  w_unused_hi;

    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_push   = spk_in_config_we & ~w_full;
    assign w_head   = r_mem[r_rptr];
    assign w_type   = w_head[T_LSB +: FTW];
    assign w_op     = w_head[O_LSB +: 2];
    assign w_addr   = w_head[A_LSB +: CAW];
    assign w_data   = w_head[D_LSB +: CDW];
    assign w_x      = w_head[X_LSB +: XW];
    assign w_y      = w_head[0 +: YW];
    assign w_is_cfg = (w_type == CFG_TYPE);
    assign w_unused_hi = ^w_head[FW-1:UW];

`ifdef CFG_PARITY_EN
    assign w_par_ok   = f_parity_ok(w_head);
    assign err_parity = r_err_parity;
`else
    assign w_par_ok   = 1'b1;
`endif

    // Head consumption: bus commands wait out hold, everything else is discarded immediately.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_empty) begin
                    w_pop = 1'b0;
                end else if (!w_par_ok || !w_is_cfg) begin
                    w_pop = 1'b1;
                end else if ((w_op == OP_WR) || (w_op == OP_RD)) begin
                    w_pop = ~r_hold;
                end else begin
                    w_pop = 1'b1;
                end
            end
            S_BURST: w_pop = ~w_empty & ~r_hold;
            default: w_pop = 1'b0;
        endcase
    end

    // Input FIFO storage, pointers, occupancy and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= spk_in_config_wdata;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (spk_in_config_we && w_full) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    // Command FSM with registered bus strobes, reply path and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_hold        <= 1'b0;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_re          <= 1'b0;
            r_raddr       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_lat         <= 3'd0;
            r_rdata       <= '0;
            r_reply_we    <= 1'b0;
            r_reply_wdata <= '0;
            r_base        <= '0;
            r_rem         <= '0;
            r_err_proto   <= 1'b0;
            r_err_parity  <= 1'b0;
        end else begin
            r_hold     <= hold;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_reply_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop && !w_par_ok) begin
                        r_err_parity <= 1'b1;
                    end else if (w_pop && w_is_cfg) begin
                        case (w_op)
                            OP_WR: begin
                                r_we    <= 1'b1;
                                r_waddr <= w_addr;
                                r_wdata <= w_data;
                                r_state <= S_WR;
                            end
                            OP_RD: begin
                                r_re    <= 1'b1;
                                r_raddr <= w_addr;
                                r_x     <= w_x;
                                r_y     <= w_y;
                                r_state <= S_RD_REQ;
                            end
                            OP_BURST: begin
                                r_base <= w_addr;
                                r_rem  <= w_data[BCW-1:0];
                                if (w_data[BCW-1:0] != '0) begin
                                    r_state <= S_BURST;
                                end
                            end
                            default: r_err_proto <= 1'b1;
                        endcase
                    end
                end
                S_WR: r_state <= S_IDLE;
                S_RD_REQ: begin
                    r_lat   <= 3'd1;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_lat == LAT_END) begin
                        r_rdata <= cfg_rdata;
                        r_state <= S_REPLY;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                S_REPLY: begin
                    if (!spk_out_config_full) begin
                        r_reply_we    <= 1'b1;
                        r_reply_wdata <= {r_x, r_y, r_rdata};
                        r_state       <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (w_pop && !w_par_ok) begin
                        r_err_parity <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (w_pop) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_base;
                        r_wdata <= w_head[CDW-1:0];
                        r_base  <= r_base + ADDR_ONE;
                        r_rem   <= r_rem - BCNT_ONE;
                        if (r_rem == BCNT_ONE) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign config_spk_in_credit = w_pop;
    assign cfg_we          = r_we;
    assign cfg_waddr       = r_waddr;
    assign cfg_wdata       = r_wdata;
    assign cfg_re          = r_re;
    assign cfg_raddr       = r_raddr;
    assign cfg_reply_we    = r_reply_we;
    assign cfg_reply_wdata = r_reply_wdata;
    assign busy            = (r_state != S_IDLE) | ~w_empty;
    assign err_overflow    = r_err_overflow;
    assign err_proto       = r_err_proto;

endmodule

// File: tb/tb_config_flit_engine.sv
// Directed bench for config_flit_engine (RD_LAT=2): write, read/reply, burst wrap, hold, overflow, errors, reset abort.
module tb_config_flit_engine;

    localparam logic [2:0] CFG = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spk_in_config_we = 1'b0;
    logic [58:0] spk_in_config_wdata = '0;
    logic        config_spk_in_credit;
    logic        hold = 1'b0;
    logic        cfg_we;
    logic [14:0] cfg_waddr;
    logic [20:0] cfg_wdata;
    logic        cfg_re;
    logic [14:0] cfg_raddr;
    logic [20:0] cfg_rdata;
    logic        spk_out_config_full = 1'b0;
    logic        cfg_reply_we;
    logic [28:0] cfg_reply_wdata;
    logic        busy;
    logic        err_overflow;
    logic        err_proto;
`ifdef CFG_PARITY_EN
    logic        err_parity;
`endif

    always #5 clk = ~clk;

    config_flit_engine #(.RD_LAT(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .spk_in_config_we     (spk_in_config_we),
        .spk_in_config_wdata  (spk_in_config_wdata),
        .config_spk_in_credit (config_spk_in_credit),
        .hold                 (hold),
        .cfg_we               (cfg_we),
        .cfg_waddr            (cfg_waddr),
        .cfg_wdata            (cfg_wdata),
        .cfg_re               (cfg_re),
        .cfg_raddr            (cfg_raddr),
        .cfg_rdata            (cfg_rdata),
        .spk_out_config_full  (spk_out_config_full),
        .cfg_reply_we         (cfg_reply_we),
        .cfg_reply_wdata      (cfg_reply_wdata),
        .busy                 (busy),
        .err_overflow         (err_overflow),
`ifdef CFG_PARITY_EN
        .err_parity           (err_parity),
`endif
        .err_proto            (err_proto)
    );

    // Read-data model: the valid word appears exactly two cycles after cfg_re, garbage otherwise.
    logic [1:0] re_pipe;
    always @(posedge clk) begin
        if (rst) re_pipe <= 2'b00;
        else     re_pipe <= {re_pipe[0], cfg_re};
    end
    assign cfg_rdata = re_pipe[1] ? 21'h00055 : 21'h1F0F0;

    int n_credit = 0, n_we = 0, n_re = 0, n_reply = 0;
    always @(negedge clk) begin
        if (config_spk_in_credit) n_credit <= n_credit + 1;
        if (cfg_we)               n_we     <= n_we + 1;
        if (cfg_re)               n_re     <= n_re + 1;
        if (cfg_reply_we)         n_reply  <= n_reply + 1;
    end

    int n_checks = 0, n_pass = 0;
    int b_cr, b_we, b_re, b_rp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_cr = n_credit; b_we = n_we; b_re = n_re; b_rp = n_reply;
    endtask

    function automatic logic [58:0] mk(input logic [2:0] ty, input logic [1:0] op, input logic [14:0] a,
                                       input logic [20:0] d, input logic [3:0] x, input logic [3:0] y);
        return {10'b0, ty, op, a, d, x, y};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("rst_we", cfg_we, 1'b0);
        check("rst_re", cfg_re, 1'b0);
        check("rst_reply", cfg_reply_we, 1'b0);
        check("rst_credit", config_spk_in_credit, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", err_overflow, 1'b0);
        check("rst_proto", err_proto, 1'b0);
        check("rst_waddr", cfg_waddr, 15'h0000);
        rst = 1'b0;
        step();

        // Single write: push in cycle 0, strobe in cycle 2.
        snap();
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(CFG, 2'b00, 15'h0123, 21'h1ABCD, 4'd0, 4'd0);
        step(); spk_in_config_we = 1'b0;
        check("wr_credit_c1", config_spk_in_credit, 1'b1);
        check("wr_we_c1", cfg_we, 1'b0);
        step();
        check("wr_we_c2", cfg_we, 1'b1);
        check("wr_waddr", cfg_waddr, 15'h0123);
        check("wr_wdata", cfg_wdata, 21'h1ABCD);
        step();
        check("wr_we_c3", cfg_we, 1'b0);
        step();
        check("wr_credits", n_credit - b_cr, 1);
        check("wr_count", n_we - b_we, 1);
        check("wr_addr_held", cfg_waddr, 15'h0123);

        // Read with reply sink full for three REPLY cycles.
        snap();
        spk_out_config_full = 1'b1;
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(CFG, 2'b01, 15'h0040, 21'h0, 4'd3, 4'd5);
        step(); spk_in_config_we = 1'b0;
        step();
        check("rd_re_c2", cfg_re, 1'b1);
        check("rd_raddr", cfg_raddr, 15'h0040);
        check("rd_we_c2", cfg_we, 1'b0);
        repeat (6) step();
        check("rd_reply_blocked", cfg_reply_we, 1'b0);
        check("rd_reply_none", n_reply - b_rp, 0);
        spk_out_config_full = 1'b0;
        step();
        check("rd_reply_we", cfg_reply_we, 1'b1);
        check("rd_reply_data", cfg_reply_wdata, 29'h6A00055);
        step();
        check("rd_reply_off", cfg_reply_we, 1'b0);
        check("rd_re_count", n_re - b_re, 1);
        check("rd_reply_count", n_reply - b_rp, 1);
        check("rd_credits", n_credit - b_cr, 1);

        // Burst of 3 starting at 0x7FFE wraps to 0x0000.
        snap();
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(CFG, 2'b10, 15'h7FFE, 21'd3, 4'd0, 4'd0);
        step(); spk_in_config_wdata = {38'b0, 21'h00011};
        step(); spk_in_config_wdata = {38'b0, 21'h00022};
        check("bu_we_c2", cfg_we, 1'b0);
        step(); spk_in_config_wdata = {38'b0, 21'h00033};
        check("bu_we1", cfg_we, 1'b1);
        check("bu_addr1", cfg_waddr, 15'h7FFE);
        check("bu_data1", cfg_wdata, 21'h00011);
        step(); spk_in_config_we = 1'b0;
        check("bu_we2", cfg_we, 1'b1);
        check("bu_addr2", cfg_waddr, 15'h7FFF);
        check("bu_data2", cfg_wdata, 21'h00022);
        step();
        check("bu_we3", cfg_we, 1'b1);
        check("bu_addr3", cfg_waddr, 15'h0000);
        check("bu_data3", cfg_wdata, 21'h00033);
        step();
        check("bu_we_end", cfg_we, 1'b0);
        check("bu_busy_end", busy, 1'b0);
        step();
        check("bu_credits", n_credit - b_cr, 4);
        check("bu_writes", n_we - b_we, 3);

        // Hold for 10 cycles with a write at the head.
        snap();
        hold = 1'b1;
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(CFG, 2'b00, 15'h0200, 21'h00777, 4'd0, 4'd0);
        step(); spk_in_config_we = 1'b0;
        repeat (9) step();
        check("hold_we", cfg_we, 1'b0);
        check("hold_credits", n_credit - b_cr, 0);
        check("hold_writes", n_we - b_we, 0);
        check("hold_busy", busy, 1'b1);
        hold = 1'b0;
        step();
        check("hold_we_c1", cfg_we, 1'b0);
        check("hold_pop_c1", config_spk_in_credit, 1'b1);
        step();
        check("hold_we_c2", cfg_we, 1'b1);
        check("hold_waddr", cfg_waddr, 15'h0200);
        step();

        // Five pushes into a depth-4 FIFO while held.
        snap();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            spk_in_config_we = 1'b1;
            spk_in_config_wdata = mk(CFG, 2'b00, 15'(15'h0300 + i), 21'(21'h00100 + i), 4'd0, 4'd0);
            step();
        end
        spk_in_config_we = 1'b0;
        check("ovf_flag", err_overflow, 1'b1);
        hold = 1'b0;
        repeat (12) step();
        check("ovf_writes", n_we - b_we, 4);
        check("ovf_credits", n_credit - b_cr, 4);
        check("ovf_last_addr", cfg_waddr, 15'h0303);
        check("ovf_last_data", cfg_wdata, 21'h00103);
        check("ovf_sticky", err_overflow, 1'b1);
        check("ovf_busy", busy, 1'b0);

        // Foreign flit type, reserved op and zero-length burst.
        snap();
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(3'b001, 2'b00, 15'h0055, 21'h1, 4'd0, 4'd0);
        step(); spk_in_config_we = 1'b0;
        check("nc_credit", config_spk_in_credit, 1'b1);
        step(); step();
        check("nc_writes", n_we - b_we, 0);
        check("nc_proto", err_proto, 1'b0);
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(CFG, 2'b11, 15'h0055, 21'h1, 4'd0, 4'd0);
        step(); spk_in_config_we = 1'b0;
        check("op3_credit", config_spk_in_credit, 1'b1);
        step();
        check("op3_proto", err_proto, 1'b1);
        snap();
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(CFG, 2'b10, 15'h0010, 21'd0, 4'd0, 4'd0);
        step(); spk_in_config_we = 1'b0;
        step();
        check("n0_busy", busy, 1'b0);
        step();
        check("n0_credits", n_credit - b_cr, 1);
        check("n0_writes", n_we - b_we, 0);

        // Reset while waiting for read data with two writes queued.
        spk_in_config_we = 1'b1; spk_in_config_wdata = mk(CFG, 2'b01, 15'h0010, 21'h0, 4'd1, 4'd2);
        step(); spk_in_config_wdata = mk(CFG, 2'b00, 15'h0400, 21'h00001, 4'd0, 4'd0);
        step(); spk_in_config_wdata = mk(CFG, 2'b00, 15'h0401, 21'h00002, 4'd0, 4'd0);
        step(); spk_in_config_we = 1'b0;
        rst = 1'b1;
        step();
        check("ra_we", cfg_we, 1'b0);
        check("ra_re", cfg_re, 1'b0);
        check("ra_reply", cfg_reply_we, 1'b0);
        check("ra_credit", config_spk_in_credit, 1'b0);
        check("ra_busy", busy, 1'b0);
        check("ra_ovf", err_overflow, 1'b0);
        check("ra_proto", err_proto, 1'b0);
        check("ra_waddr", cfg_waddr, 15'h0000);
        snap();
        rst = 1'b0;
        repeat (8) step();
        check("ra_post_credits", n_credit - b_cr, 0);
        check("ra_post_writes", n_we - b_we, 0);
        check("ra_post_reply", n_reply - b_rp, 0);
        check("ra_post_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
